// File: rtl/aes_round_seq_cu_if.sv
// Handshake and datapath-control bundle between the AES block wrapper/datapath and the round sequencer.
interface aes_round_seq_cu_if #(
  parameter int RW = 4
);
  logic          key_load;
  logic [1:0]    key_mode;
  logic          in_valid;
  logic          in_ready;
  logic          dec;
  logic          out_valid;
  logic          out_ready;
  logic          kexp_en;
  logic [RW-1:0] kidx;
  logic [RW-1:0] rk_sel;
  logic          ark_only;
  logic          rnd_en;
  logic          mix_en;
  logic          dec_mode;
  logic          key_ok;
  logic          busy;
  logic          err;

  modport master (
    output key_load, key_mode, in_valid, dec, out_ready,
    input  in_ready, out_valid, kexp_en, kidx, rk_sel, ark_only, rnd_en,
           mix_en, dec_mode, key_ok, busy, err
  );

  modport slave (
    input  key_load, key_mode, in_valid, dec, out_ready,
    output in_ready, out_valid, kexp_en, kidx, rk_sel, ark_only, rnd_en,
           mix_en, dec_mode, key_ok, busy, err
  );
endinterface

// File: rtl/aes_round_seq_cu.sv
// AES-128/192/256 control unit: sequences key expansion once per key, then the
// ARK0 / ROUND / FINAL schedule for each block, encrypt or decrypt.
module aes_round_seq_cu #(
  parameter int NR128  = 10,
  parameter int NR192  = 12,
  parameter int NR256  = 14,
  parameter int RW     = 4,
  parameter int DEC_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  aes_round_seq_cu_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYGEN, S_READY, S_ARK0, S_ROUND, S_FINAL, S_OUTV
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic          dec_q;
  logic [RW-1:0] kidx_q;
  logic [RW-1:0] round_q;
  logic          key_ok_q;
  logic          err_q;
  logic [RW-1:0] nr;
  logic          key_req, key_go, key_bad, accept;

  function automatic logic [RW-1:0] nr_of(input logic [1:0] m);
    case (m)
      2'b01:   return RW'(NR192);
      2'b10:   return RW'(NR256);
      default: return RW'(NR128);
    endcase
  endfunction

  assign nr      = nr_of(mode_q);
  assign key_req = bus.key_load && (state == S_IDLE || state == S_READY);
  assign key_go  = key_req && (bus.key_mode != 2'b11);
  assign key_bad = key_req && (bus.key_mode == 2'b11);
  // key_load wins over a simultaneous block offer, even a reserved-mode one
  assign accept  = (state == S_READY) && !bus.key_load && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (key_go) state_nxt = S_KEYGEN;
      S_KEYGEN: if (kidx_q >= nr) state_nxt = S_READY;
      S_READY: begin
        if (key_go)      state_nxt = S_KEYGEN;
        else if (accept) state_nxt = S_ARK0;
      end
      S_ARK0:   state_nxt = S_ROUND;
      S_ROUND:  if (round_q >= nr - RW'(1)) state_nxt = S_FINAL;
      S_FINAL:  state_nxt = S_OUTV;
      S_OUTV:   if (bus.out_ready) state_nxt = S_READY;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 2'b00;
      dec_q    <= 1'b0;
      kidx_q   <= '0;
      round_q  <= '0;
      key_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= key_bad;
      if (key_go) begin
        mode_q   <= bus.key_mode;
        key_ok_q <= 1'b0;
        kidx_q   <= RW'(1);
      end else if (state == S_KEYGEN) begin
        if (kidx_q >= nr) key_ok_q <= 1'b1;
        else              kidx_q   <= kidx_q + RW'(1);
      end
      if (accept) dec_q <= bus.dec & (DEC_EN != 0);
      if (state == S_ARK0)
        round_q <= RW'(1);
      else if (state == S_ROUND && round_q < nr - RW'(1))
        round_q <= round_q + RW'(1);
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.kexp_en   = 1'b0;
    bus.kidx      = '0;
    bus.rk_sel    = '0;
    bus.ark_only  = 1'b0;
    bus.rnd_en    = 1'b0;
    bus.mix_en    = 1'b0;
    bus.dec_mode  = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      S_KEYGEN: begin
        bus.kexp_en = 1'b1;
        bus.kidx    = kidx_q;
        bus.busy    = 1'b1;
      end
      S_READY: bus.in_ready = ~bus.key_load;
      S_ARK0: begin
        bus.ark_only = 1'b1;
        bus.rk_sel   = dec_q ? nr : '0;
        bus.dec_mode = dec_q;
        bus.busy     = 1'b1;
      end
      S_ROUND: begin
        bus.rnd_en   = 1'b1;
        bus.mix_en   = 1'b1;
        bus.rk_sel   = dec_q ? (nr - round_q) : round_q;
        bus.dec_mode = dec_q;
        bus.busy     = 1'b1;
      end
      S_FINAL: begin
        bus.rnd_en   = 1'b1;
        bus.rk_sel   = dec_q ? '0 : nr;
        bus.dec_mode = dec_q;
        bus.busy     = 1'b1;
      end
      S_OUTV: begin
        bus.out_valid = 1'b1;
        bus.dec_mode  = dec_q;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.key_ok = key_ok_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_aes_round_seq_cu.sv
// Bench for aes_round_seq_cu: directed scenarios then random traffic, checked
// against a schedule-queue model of the expected control outputs.
module tb_aes_round_seq_cu;
  localparam int RW = 4;

  typedef struct packed {
    logic          kexp;
    logic [RW-1:0] kidx;
    logic          ark;
    logic          rnd;
    logic          mix;
    logic [RW-1:0] rk;
    logic          dm;
    logic          kok;
  } sched_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_seq_cu_if #(.RW(RW)) bus();

  aes_round_seq_cu #(.RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  sched_t q[$];
  bit     m_kok, m_outv, m_dec, m_err;
  int     cyc, n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, want);
    end
  endtask

  function automatic sched_t mk(bit kexp, int kidx, bit ark, bit rnd, bit mix,
                                int rk, bit dm, bit kok);
    sched_t s;
    s.kexp = kexp; s.kidx = RW'(kidx); s.ark = ark; s.rnd = rnd;
    s.mix  = mix;  s.rk   = RW'(rk);   s.dm  = dm;  s.kok = kok;
    return s;
  endfunction

  function automatic int nr_of(logic [1:0] m);
    return (m == 2'b01) ? 12 : (m == 2'b10) ? 14 : 10;
  endfunction

  int m_nr;

  task automatic step(input bit r, input bit kl, input logic [1:0] km,
                      input bit iv, input bit d, input bit ordy);
    sched_t e;
    bit     has;
    @(negedge clk);
    rst = r; bus.key_load = kl; bus.key_mode = km;
    bus.in_valid = iv; bus.dec = d; bus.out_ready = ordy;
    #1;
    has = (q.size() > 0);
    e   = has ? q[0] : '0;
    chk("in_ready",  bus.in_ready,  32'(!has && !m_outv && m_kok && !kl));
    chk("out_valid", bus.out_valid, 32'(!has && m_outv));
    chk("kexp_en",   bus.kexp_en,   32'(e.kexp));
    chk("kidx",      bus.kidx,      32'(e.kidx));
    chk("rk_sel",    bus.rk_sel,    32'(e.rk));
    chk("ark_only",  bus.ark_only,  32'(e.ark));
    chk("rnd_en",    bus.rnd_en,    32'(e.rnd));
    chk("mix_en",    bus.mix_en,    32'(e.mix));
    chk("dec_mode",  bus.dec_mode,  32'(has ? e.dm : (m_outv && m_dec)));
    chk("key_ok",    bus.key_ok,    32'(has ? e.kok : m_kok));
    chk("busy",      bus.busy,      32'(has || m_outv));
    chk("err",       bus.err,       32'(m_err));
    @(posedge clk);
    if (r) begin
      q.delete(); m_kok = 0; m_outv = 0; m_dec = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (q.size() > 0) begin
        void'(q.pop_front());
      end else if (m_outv) begin
        if (ordy) m_outv = 0;
      end else if (kl) begin
        if (km == 2'b11) m_err = 1;
        else begin
          m_nr  = nr_of(km);
          m_kok = 1;
          for (int i = 1; i <= m_nr; i++) q.push_back(mk(1, i, 0, 0, 0, 0, 0, 0));
        end
      end else if (m_kok && iv) begin
        m_dec  = d;
        m_outv = 1;
        q.push_back(mk(0, 0, 1, 0, 0, d ? m_nr : 0, d, 1));
        for (int r2 = 1; r2 < m_nr; r2++)
          q.push_back(mk(0, 0, 0, 1, 1, d ? m_nr - r2 : r2, d, 1));
        q.push_back(mk(0, 0, 0, 1, 0, d ? 0 : m_nr, d, 1));
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0, ordy);
  endtask

  initial begin
    rst = 1; bus.key_load = 0; bus.key_mode = 0; bus.in_valid = 0;
    bus.dec = 0; bus.out_ready = 0;
    n_cmp = 0; n_err = 0; cyc = 0; m_nr = 10;
    @(posedge clk);
    q.delete(); m_kok = 0; m_outv = 0; m_dec = 0; m_err = 0;

    step(1, 0, 2'b00, 0, 0, 0);
    // AES-128 key expansion, then an encrypt block held under backpressure
    step(0, 1, 2'b00, 0, 0, 0);
    idle(12, 0);
    step(0, 0, 2'b00, 1, 0, 0);
    idle(16, 0);
    idle(2, 1);
    // second block reuses the key
    step(0, 0, 2'b00, 1, 0, 1);
    idle(14, 1);
    // AES-256 decrypt
    step(0, 1, 2'b10, 0, 0, 1);
    idle(16, 1);
    step(0, 0, 2'b00, 1, 1, 1);
    idle(18, 1);
    // key_load together with in_valid in READY
    step(0, 1, 2'b00, 1, 0, 1);
    idle(12, 1);
    // reserved mode: err pulse, key kept
    step(0, 1, 2'b11, 1, 0, 1);
    idle(2, 1);
    // reset in the middle of a block, then blocks are refused
    step(0, 0, 2'b00, 1, 0, 1);
    idle(5, 1);
    step(1, 0, 2'b00, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 2'b00, 1, 0, 1);
    // AES-192 via mode 01
    step(0, 1, 2'b01, 0, 0, 1);
    idle(14, 1);
    step(0, 0, 2'b00, 1, 1, 0);
    idle(16, 1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 399) == 0, $urandom_range(0, 11) == 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
